// File: rtl/dtree_scheduler.sv
// dtree_scheduler: shares one dtree classifier core among CHANNELS requesters.
// Round-robin arbitration picks a channel and latches its feature vector. The
// core is restarted for one cycle and the features are streamed one per cycle.
// The first level/path result, or a watchdog expiry, is returned on a
// valid/ready result port, tagged with the channel index.
//
// Ports:
//   clk, reset             clock, asynchronous active-high reset
//   req[CHANNELS]          level requests, held until granted
//   features               channel c, feature k at [(c*FEATURES+k)*IN_WIDTH +: IN_WIDTH]
//   grant[CHANNELS]        one-hot pulse in the cycle the vector is consumed (LOAD)
//   tree_reset             core reset = reset | LOAD
//   tree_sample            sample fed to the core, 0 outside the streaming phase
//   tree_level/path/valid  core result
//   res_valid/res_ready    result handshake
//   res_channel/level/path/timeout  captured result, stable while res_valid

// One feature slot of the latched vector: picks its feature from the granted channel.
module dtree_sched_slot #(
  parameter int CHANNELS = 4,
  parameter int IN_WIDTH = 10,
  parameter int CW       = 2
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               load,
  input  logic [CW-1:0]                      sel,
  input  logic [CHANNELS-1:0][IN_WIDTH-1:0]  cand,
  output logic [IN_WIDTH-1:0]                q
);
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     q <= '0;
    else if (load) q <= cand[sel];
  end
endmodule

module dtree_scheduler #(
  parameter int CHANNELS = 4,
  parameter int FEATURES = 3,
  parameter int IN_WIDTH = 10,
  parameter int TIMEOUT  = 16,
  localparam int LW = $clog2(FEATURES),
  localparam int CW = $clog2(CHANNELS)
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [CHANNELS-1:0]                 req,
  input  logic [CHANNELS*FEATURES*IN_WIDTH-1:0] features,
  output logic [CHANNELS-1:0]                 grant,
  output logic                                tree_reset,
  output logic [IN_WIDTH-1:0]                 tree_sample,
  input  logic [LW-1:0]                       tree_level,
  input  logic [LW-1:0]                       tree_path,
  input  logic                                tree_valid,
  output logic                                res_valid,
  input  logic                                res_ready,
  output logic [CW-1:0]                       res_channel,
  output logic [LW-1:0]                       res_level,
  output logic [LW-1:0]                       res_path,
  output logic                                res_timeout
);
  // idx runs 0..FEATURES; the value FEATURES marks the wait phase.
  localparam int IW = $clog2(FEATURES + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, LOAD, STREAM, DONE} state_t;

  state_t                            state, state_nxt;
  logic [CW-1:0]                     last, sel, arb_sel, cand_ch;
  logic                              arb_hit, load_vec;
  logic [IW-1:0]                     idx;
  logic [TW-1:0]                     wd;
  logic                              wd_expired;
  logic [FEATURES-1:0][IN_WIDTH-1:0] vec;

  // Round-robin: first set req bit searching upward from last+1, wrapping.
  always_comb begin
    arb_hit = 1'b0;
    arb_sel = '0;
    cand_ch = '0;
    for (int i = 1; i <= CHANNELS; i++) begin
      cand_ch = CW'((int'(last) + i) % CHANNELS);
      if (!arb_hit && req[cand_ch]) begin
        arb_hit = 1'b1;
        arb_sel = cand_ch;
      end
    end
  end

  assign load_vec   = (state == IDLE) && arb_hit;
  assign wd_expired = (wd == TW'(TIMEOUT - 1));

  for (genvar k = 0; k < FEATURES; k++) begin : g_feat
    logic [CHANNELS-1:0][IN_WIDTH-1:0] cand;
    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      assign cand[c] = features[(c*FEATURES + k)*IN_WIDTH +: IN_WIDTH];
    end
    dtree_sched_slot #(
      .CHANNELS (CHANNELS),
      .IN_WIDTH (IN_WIDTH),
      .CW       (CW)
    ) u_slot (
      .clk   (clk),
      .reset (reset),
      .load  (load_vec),
      .sel   (arb_sel),
      .cand  (cand),
      .q     (vec[k])
    );
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (arb_hit) state_nxt = LOAD;
      LOAD:    state_nxt = STREAM;
      // tree_valid wins over a simultaneous watchdog expiry
      STREAM:  if (tree_valid || wd_expired) state_nxt = DONE;
      DONE:    if (res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state. tree_reset stays combinational so the core
  // restarts in the same cycle the scheduler enters LOAD.
  always_comb begin
    grant = '0;
    if (state == LOAD) grant[sel] = 1'b1;
  end

  assign tree_reset = reset | (state == LOAD);
  assign res_valid  = (state == DONE);

  always_comb begin
    tree_sample = '0;
    if (state == STREAM)
      for (int k = 0; k < FEATURES; k++)
        if (idx == IW'(k)) tree_sample = vec[k];
  end

  // Datapath: selection, stream index, watchdog, result capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last        <= CW'(CHANNELS - 1);
      sel         <= '0;
      idx         <= '0;
      wd          <= '0;
      res_channel <= '0;
      res_level   <= '0;
      res_path    <= '0;
      res_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: if (arb_hit) sel <= arb_sel;
        LOAD: begin
          idx <= '0;
          wd  <= '0;
        end
        STREAM: begin
          if (idx != IW'(FEATURES)) idx <= idx + 1'b1;
          wd <= wd + 1'b1;
          if (tree_valid) begin
            res_channel <= sel;
            res_level   <= tree_level;
            res_path    <= tree_path;
            res_timeout <= 1'b0;
          end else if (wd_expired) begin
            res_channel <= sel;
            res_level   <= '0;
            res_path    <= '0;
            res_timeout <= 1'b1;
          end
        end
        DONE: if (res_ready) last <= sel;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_dtree_scheduler.sv
// Testbench for dtree_scheduler: drives the core-side response (tree_valid,
// level, path) directly and checks grants, streamed samples and results
// against expectations derived from the arbitration and timing rules.
module tb_dtree_scheduler;
  localparam int CH = 4, F = 3, W = 10, TO = 16, LW = 2, CW = 2;

  logic                clk = 1'b0;
  logic                reset;
  logic [CH-1:0]       req;
  logic [CH*F*W-1:0]   features;
  logic [CH-1:0]       grant;
  logic                tree_reset;
  logic [W-1:0]        tree_sample;
  logic [LW-1:0]       tree_level, tree_path;
  logic                tree_valid;
  logic                res_valid, res_ready;
  logic [CW-1:0]       res_channel;
  logic [LW-1:0]       res_level, res_path;
  logic                res_timeout;

  logic [W-1:0]        fv [CH][F];
  int                  checks = 0, failures = 0, m_last = CH - 1;

  dtree_scheduler #(.CHANNELS(CH), .FEATURES(F), .IN_WIDTH(W), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req(req), .features(features), .grant(grant),
    .tree_reset(tree_reset), .tree_sample(tree_sample), .tree_level(tree_level),
    .tree_path(tree_path), .tree_valid(tree_valid), .res_valid(res_valid),
    .res_ready(res_ready), .res_channel(res_channel), .res_level(res_level),
    .res_path(res_path), .res_timeout(res_timeout)
  );

  always #5 clk = ~clk;

  always_comb begin
    features = '0;
    for (int c = 0; c < CH; c++)
      for (int k = 0; k < F; k++)
        features[(c*F + k)*W +: W] = fv[c][k];
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic rand_feat;
    for (int c = 0; c < CH; c++)
      for (int k = 0; k < F; k++)
        fv[c][k] = W'($urandom);
  endtask

  // Reference arbitration: first requesting channel after the last served one.
  function automatic int rr_pick(input logic [CH-1:0] r, input int last);
    logic [CH-1:0] b;
    for (int i = 1; i <= CH; i++) begin
      b = r >> ((last + i) % CH);
      if (b[0]) return (last + i) % CH;
    end
    return -1;
  endfunction

  task automatic do_reset;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    m_last = CH - 1;
  endtask

  // One job from an IDLE cycle with req already driven. vcyc is the cycle
  // (counted from the arbitration cycle 0) in which tree_valid is raised, or
  // -1 for a core that never answers. stall = cycles res_ready is held low.
  task automatic run_job(input int ch, input int vcyc, input int stall,
                         input logic [LW-1:0] lvl, input logic [LW-1:0] pth);
    logic [W-1:0]  snap [F];
    logic [W-1:0]  exp_s;
    logic [CH-1:0] exp_g;
    logic [LW-1:0] e_lvl, e_pth;
    logic          tmo;
    int            done;
    for (int k = 0; k < F; k++) snap[k] = fv[ch][k];
    tmo   = (vcyc < 0);
    done  = tmo ? TO + 2 : vcyc + 1;
    e_lvl = tmo ? '0 : lvl;
    e_pth = tmo ? '0 : pth;
    exp_g = CH'(1) << ch;

    checks++;
    if (res_valid !== 1'b0 || grant !== '0) begin
      failures++;
      $display("FAIL idle ch=%0d res_valid=%b grant=%b exp 0/0", ch, res_valid, grant);
    end
    tick;  // cycle 1: LOAD
    checks++;
    if (grant !== exp_g || tree_reset !== 1'b1 || tree_sample !== '0) begin
      failures++;
      $display("FAIL load_grant act=%b tree_reset=%b sample=%0d exp grant=%b tree_reset=1 sample=0",
               grant, tree_reset, tree_sample, exp_g);
    end
    rand_feat();  // inputs move on; the latched vector must not
    for (int cyc = 2; cyc < done; cyc++) begin
      tick;
      exp_s = '0;
      if (cyc - 2 < F) exp_s = snap[cyc - 2];
      checks++;
      if (tree_sample !== exp_s || grant !== '0 || tree_reset !== 1'b0 || res_valid !== 1'b0) begin
        failures++;
        $display("FAIL stream cyc=%0d sample=%0d exp=%0d grant=%b tree_reset=%b res_valid=%b",
                 cyc, tree_sample, exp_s, grant, tree_reset, res_valid);
      end
      tree_valid = (cyc == vcyc);
      tree_level = (cyc == vcyc) ? lvl : LW'($urandom);
      tree_path  = (cyc == vcyc) ? pth : LW'($urandom);
    end
    tick;  // DONE
    tree_valid = 1'b0;
    checks++;
    if (res_valid !== 1'b1 || res_channel !== CW'(ch) || res_level !== e_lvl ||
        res_path !== e_pth || res_timeout !== tmo || tree_sample !== '0) begin
      failures++;
      $display("FAIL result cyc=%0d valid=%b ch=%0d lvl=%0d path=%0d to=%b sample=%0d exp 1/%0d/%0d/%0d/%b/0",
               done, res_valid, res_channel, res_level, res_path, res_timeout, tree_sample,
               ch, e_lvl, e_pth, tmo);
    end
    for (int s = 0; s < stall; s++) begin
      res_ready  = 1'b0;
      tree_valid = 1'($urandom);  // must be ignored outside STREAM
      tree_level = LW'($urandom);
      tree_path  = LW'($urandom);
      tick;
      checks++;
      if (res_valid !== 1'b1 || res_channel !== CW'(ch) || res_level !== e_lvl ||
          res_path !== e_pth || res_timeout !== tmo || grant !== '0) begin
        failures++;
        $display("FAIL stall s=%0d valid=%b ch=%0d lvl=%0d path=%0d to=%b grant=%b exp 1/%0d/%0d/%0d/%b/0",
                 s, res_valid, res_channel, res_level, res_path, res_timeout, grant,
                 ch, e_lvl, e_pth, tmo);
      end
    end
    res_ready  = 1'b1;
    tree_valid = 1'b0;
    tick;  // IDLE after handshake
    res_ready = 1'b0;
    checks++;
    if (res_valid !== 1'b0 || grant !== '0) begin
      failures++;
      $display("FAIL turnaround res_valid=%b grant=%b exp 0/0", res_valid, grant);
    end
    m_last = ch;
  endtask

  task automatic test_reset;
    reset = 1'b1; req = '0; tree_valid = 1'b0; tree_level = '0; tree_path = '0;
    res_ready = 1'b0;
    for (int c = 0; c < CH; c++) for (int k = 0; k < F; k++) fv[c][k] = '0;
    tick; tick;
    checks++;
    if (grant !== '0 || tree_sample !== '0 || tree_reset !== 1'b1 || res_valid !== 1'b0 ||
        res_channel !== '0 || res_level !== '0 || res_path !== '0 || res_timeout !== 1'b0) begin
      failures++;
      $display("FAIL reset_values grant=%b sample=%0d tree_reset=%b valid=%b ch=%0d lvl=%0d path=%0d to=%b",
               grant, tree_sample, tree_reset, res_valid, res_channel, res_level, res_path, res_timeout);
    end
    @(negedge clk);
    reset = 1'b0;
    tick;
    checks++;
    if (tree_reset !== 1'b0 || res_valid !== 1'b0 || grant !== '0) begin
      failures++;
      $display("FAIL after_reset tree_reset=%b valid=%b grant=%b exp 0/0/0", tree_reset, res_valid, grant);
    end
  endtask

  task automatic test_single;
    fv[2][0] = W'(5); fv[2][1] = W'(-3); fv[2][2] = W'(100);
    req = 4'b0100;
    run_job(rr_pick(req, m_last), 5, 0, 2'd1, 2'd2);
  endtask

  task automatic test_round_robin;
    req = 4'b1111;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      rand_feat();
      run_job(i % CH, $urandom_range(2, TO + 1), 0, LW'($urandom), LW'($urandom));
    end
  endtask

  task automatic test_early;
    rand_feat();
    req = 4'b1000;
    run_job(rr_pick(req, m_last), 3, 0, 2'd3, 2'd1);
  endtask

  task automatic test_watchdog;
    rand_feat();
    req = 4'b0001;
    run_job(rr_pick(req, m_last), -1, 1, 2'd3, 2'd3);
    req = 4'b0100;  // answer on the very last watchdog cycle still counts
    run_job(rr_pick(req, m_last), TO + 1, 0, 2'd2, 2'd1);
  endtask

  task automatic test_backpressure;
    rand_feat();
    req = 4'b0010;
    run_job(rr_pick(req, m_last), 4, 10, 2'd3, 2'd1);
    run_job(1, 3, 0, 2'd2, 2'd3);  // re-granted right after the IDLE turnaround
  endtask

  task automatic test_reset_mid;
    rand_feat();
    req = 4'b0001;
    tick; tick; tick;  // LOAD, then two STREAM cycles
    #2 reset = 1'b1;
    #1;
    checks++;
    if (grant !== '0 || tree_sample !== '0 || tree_reset !== 1'b1 || res_valid !== 1'b0 ||
        res_channel !== '0 || res_level !== '0 || res_path !== '0 || res_timeout !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid grant=%b sample=%0d tree_reset=%b valid=%b ch=%0d lvl=%0d path=%0d to=%b",
               grant, tree_sample, tree_reset, res_valid, res_channel, res_level, res_path, res_timeout);
    end
    req = 4'b1010;
    @(negedge clk);
    reset = 1'b0;
    m_last = CH - 1;
    run_job(1, 4, 0, 2'd1, 2'd1);
  endtask

  task automatic test_random;
    int ch, vcyc;
    for (int n = 0; n < 25; n++) begin
      rand_feat();
      req  = CH'($urandom_range(1, 15));
      ch   = rr_pick(req, m_last);
      vcyc = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(2, TO + 1));
      run_job(ch, vcyc, $urandom_range(0, 3), LW'($urandom), LW'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_early();
    test_watchdog();
    test_backpressure();
    test_reset_mid();
    test_random();
    req = '0;
    tick;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
